// File: rtl/spi_burst_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : spi_burst_master_if
//  Purpose  : Command, TX/RX word streams, Avalon-MM master bus and bridge irq
//             bundled for spi_burst_master.
//  Revision : 1.0 - initial release
// ============================================================================
interface spi_burst_master_if;
   // Burst command and status
   logic        start;
   logic [7:0]  len;
   logic        busy;
   logic        done;
   logic        error;
   // TX word stream (into the master)
   logic [31:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;
   // RX word stream (out of the master)
   logic [31:0] rx_data;
   logic        rx_valid;
   logic        rx_ready;
   // Avalon-MM master bus towards the SPI bridge
   logic [7:0]  av_address;
   logic        av_chip_select;
   logic        av_write;
   logic        av_read;
   logic [31:0] av_write_data;
   logic [31:0] av_read_data;
   logic        av_wait_request;
   // Bridge RX-data-available level
   logic        irq;

   modport master (
      input  start, len, tx_data, tx_valid, rx_ready,
             av_read_data, av_wait_request, irq,
      output busy, done, error, tx_ready, rx_data, rx_valid,
             av_address, av_chip_select, av_write, av_read, av_write_data
   );

   modport slave (
      output start, len, tx_data, tx_valid, rx_ready,
             av_read_data, av_wait_request, irq,
      input  busy, done, error, tx_ready, rx_data, rx_valid,
             av_address, av_chip_select, av_write, av_read, av_write_data
   );
endinterface
`default_nettype wire

// File: rtl/spi_burst_master.sv
`default_nettype none
// ============================================================================
//  Module   : spi_burst_master
//  Purpose  : Avalon-MM master feeding the SPI Avalon bridge. Writes a burst
//             of TX words, reads back the same number of RX words when the
//             bridge raises irq, and limits words in flight to MAX_OUT.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_burst_master #(
   parameter logic [7:0]  TX_ADDR = 8'h00,
   parameter logic [7:0]  RX_ADDR = 8'h04,
   parameter int unsigned MAX_OUT = 4,
   parameter int unsigned TIMEOUT = 1024
) (
   input wire                 clk_120MHz,
   input wire                 reset_n,
   spi_burst_master_if.master bus
);

   // Stall counter only needs to reach TIMEOUT-1
   localparam int unsigned       c_TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);
   localparam logic [7:0]        c_MAX_OUT  = 8'(MAX_OUT);

   localparam logic [2:0] c_ST_IDLE  = 3'd0;
   localparam logic [2:0] c_ST_ARB   = 3'd1;
   localparam logic [2:0] c_ST_WRITE = 3'd2;
   localparam logic [2:0] c_ST_READ  = 3'd3;
   localparam logic [2:0] c_ST_FIN   = 3'd4;

   logic [2:0]         r_state;
   logic [2:0]         w_state_nxt;
   logic [7:0]         r_len;
   logic [7:0]         r_wr_cnt;
   logic [7:0]         r_rd_cnt;
   logic [c_TMO_W-1:0] r_tmo;
   logic               r_tmo_err;
   logic               r_cs;
   logic               r_wr;
   logic               r_rd;
   logic [7:0]         r_addr;
   logic [31:0]        r_wdata;
   logic [31:0]        r_rx_data;
   logic               r_rx_valid;

   logic [7:0]         w_outstanding;
   logic               w_arb_fin;
   logic               w_go_rd;
   logic               w_go_wr;
   logic               w_on_bus;
   logic               w_tmo_hit;
   logic               w_busy;
   logic               w_done;
   logic               w_error;
   logic               w_tx_ready;

   // Arbitration terms: finish first, then drain reads, then throttled writes
   assign w_outstanding = r_wr_cnt - r_rd_cnt;
   assign w_arb_fin     = (r_rd_cnt == r_len);
   assign w_go_rd       = !w_arb_fin && bus.irq && (r_rd_cnt < r_wr_cnt) && !r_rx_valid;
   assign w_go_wr       = !w_arb_fin && !w_go_rd && (r_wr_cnt < r_len) && bus.tx_valid
                          && (w_outstanding < c_MAX_OUT);
   assign w_on_bus      = (r_state == c_ST_WRITE) || (r_state == c_ST_READ);
   assign w_tmo_hit     = w_on_bus && bus.av_wait_request && (r_tmo == c_TMO_LAST);

   // State register
   always_ff @(posedge clk_120MHz or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decision
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (bus.start) begin
               w_state_nxt = (bus.len == 8'd0) ? c_ST_FIN : c_ST_ARB;
            end
         end
         c_ST_ARB: begin
            if (w_arb_fin) begin
               w_state_nxt = c_ST_FIN;
            end else if (w_go_rd) begin
               w_state_nxt = c_ST_READ;
            end else if (w_go_wr) begin
               w_state_nxt = c_ST_WRITE;
            end
         end
         c_ST_WRITE, c_ST_READ: begin
            if (!bus.av_wait_request) begin
               w_state_nxt = c_ST_ARB;
            end else if (w_tmo_hit) begin
               w_state_nxt = c_ST_FIN;
            end
         end
         c_ST_FIN:  w_state_nxt = c_ST_IDLE;
         default:   w_state_nxt = c_ST_IDLE;
      endcase
   end

   // State-decoded outputs; tx_ready only in the ARB cycle that picks a write
   always_comb begin
      w_busy     = (r_state != c_ST_IDLE);
      w_done     = (r_state == c_ST_FIN);
      w_error    = (r_state == c_ST_FIN) && r_tmo_err;
      w_tx_ready = (r_state == c_ST_ARB) && w_go_wr;
   end

   // Counters, registered bus outputs and RX holding register
   always_ff @(posedge clk_120MHz or negedge reset_n) begin
      if (!reset_n) begin
         r_len      <= '0;
         r_wr_cnt   <= '0;
         r_rd_cnt   <= '0;
         r_tmo      <= '0;
         r_tmo_err  <= 1'b0;
         r_cs       <= 1'b0;
         r_wr       <= 1'b0;
         r_rd       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
      end else begin
         r_tmo_err <= w_tmo_hit;
         if (r_rx_valid && bus.rx_ready) begin
            r_rx_valid <= 1'b0;
         end
         case (r_state)
            c_ST_IDLE: begin
               if (bus.start && (bus.len != 8'd0)) begin
                  r_len    <= bus.len;
                  r_wr_cnt <= '0;
                  r_rd_cnt <= '0;
                  r_tmo    <= '0;
               end
            end
            c_ST_ARB: begin
               if (w_go_rd) begin
                  r_cs   <= 1'b1;
                  r_rd   <= 1'b1;
                  r_addr <= RX_ADDR;
                  r_tmo  <= '0;
               end else if (w_go_wr) begin
                  r_cs    <= 1'b1;
                  r_wr    <= 1'b1;
                  r_addr  <= TX_ADDR;
                  r_wdata <= bus.tx_data;
                  r_tmo   <= '0;
               end
            end
            c_ST_WRITE, c_ST_READ: begin
               if (!bus.av_wait_request) begin
                  r_cs <= 1'b0;
                  r_wr <= 1'b0;
                  r_rd <= 1'b0;
                  if (r_state == c_ST_WRITE) begin
                     r_wr_cnt <= r_wr_cnt + 8'd1;
                  end else begin
                     r_rx_data  <= bus.av_read_data;
                     r_rx_valid <= 1'b1;
                     r_rd_cnt   <= r_rd_cnt + 8'd1;
                  end
               end else if (w_tmo_hit) begin
                  // Abandon the access; words left in the bridge are dropped
                  r_cs <= 1'b0;
                  r_wr <= 1'b0;
                  r_rd <= 1'b0;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy           = w_busy;
   assign bus.done           = w_done;
   assign bus.error          = w_error;
   assign bus.tx_ready       = w_tx_ready;
   assign bus.rx_data        = r_rx_data;
   assign bus.rx_valid       = r_rx_valid;
   assign bus.av_address     = r_addr;
   assign bus.av_chip_select = r_cs;
   assign bus.av_write       = r_wr;
   assign bus.av_read        = r_rd;
   assign bus.av_write_data  = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_spi_burst_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_burst_master
//  Purpose  : Self-checking bench for spi_burst_master. A bridge model keeps a
//             FIFO of written words and returns a fixed transform of each one;
//             accepted TX words push their expected RX word into a scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_burst_master;
   localparam int         MAX_OUT = 4;
   localparam int         TIMEOUT = 16;
   localparam logic [7:0] TX_ADDR = 8'h00;
   localparam logic [7:0] RX_ADDR = 8'h04;

   logic clk_120MHz = 1'b0;
   logic reset_n    = 1'b0;

   spi_burst_master_if bus ();

   spi_burst_master #(
      .TX_ADDR (TX_ADDR),
      .RX_ADDR (RX_ADDR),
      .MAX_OUT (MAX_OUT),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk_120MHz (clk_120MHz),
      .reset_n    (reset_n),
      .bus        (bus.master)
   );

   always #5 clk_120MHz = ~clk_120MHz;

   int vectors = 0, miscompares = 0;
   logic [31:0] tx_src[$], exp_q[$], slv_fifo[$];
   int irq_en = 1, stall_mode = 0, rx_mode = 0;
   int wr_total = 0, rd_total = 0, last_len = 0, acc_len = 0, stall = 0;
   int done_cnt = 0, err_cnt = 0, rx_cnt = 0;
   int d0, e0, w0, r0, x0;
   logic in_acc = 1'b0, acc_wr;
   logic [7:0]  acc_addr;
   logic [31:0] acc_wd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name, input string msg);
      vectors++;
      miscompares++;
      $display("FAIL %s: %s at %0t", name, msg, $time);
   endtask

   // Bridge loopback reference: RX word = halves swapped, XOR constant
   function automatic logic [31:0] xf(input logic [31:0] w);
      return {w[15:0], w[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   // TX source: presents queued words, logs expected RX word on each handshake
   initial begin
      logic hs;
      logic [31:0] hs_data;
      bus.tx_valid = 1'b0;
      bus.tx_data  = '0;
      forever begin
         @(negedge clk_120MHz); #2;
         hs      = bus.tx_valid && bus.tx_ready;
         hs_data = bus.tx_data;
         @(posedge clk_120MHz); #1;
         if (hs && tx_src.size() > 0) begin
            void'(tx_src.pop_front());
            exp_q.push_back(xf(hs_data));
         end
         if (tx_src.size() == 0) begin
            bus.tx_valid = 1'b0;
         end else if (!bus.tx_valid) begin
            if ($urandom_range(0, 3) != 0) begin
               bus.tx_valid = 1'b1;
               bus.tx_data  = tx_src[0];
            end
         end else begin
            bus.tx_data = tx_src[0];
         end
      end
   end

   // RX sink ready pattern
   initial begin
      bus.rx_ready = 1'b0;
      forever begin
         @(posedge clk_120MHz); #1;
         case (rx_mode)
            0:       bus.rx_ready = 1'b1;
            1:       bus.rx_ready = ($urandom_range(0, 1) == 1);
            default: bus.rx_ready = 1'b0;
         endcase
      end
   end

   // RX monitor: scoreboard compare on handshake, hold check while stalled
   initial begin
      logic pend = 1'b0;
      logic [31:0] pend_data = '0;
      forever begin
         @(negedge clk_120MHz);
         if (!reset_n) begin pend = 1'b0; continue; end
         if (pend) begin
            chk("rx_valid_held", bus.rx_valid, 1);
            chk("rx_data_held", bus.rx_data, pend_data);
         end
         if (bus.rx_valid && bus.rx_ready) begin
            rx_cnt++;
            if (exp_q.size() == 0) fail("rx_unexpected", $sformatf("word %08h with empty scoreboard", bus.rx_data));
            else chk("rx_data", bus.rx_data, exp_q.pop_front());
         end
         pend      = bus.rx_valid && !bus.rx_ready;
         pend_data = bus.rx_data;
      end
   end

   // Status monitor: done/error pulses
   initial begin
      forever begin
         @(negedge clk_120MHz);
         if (reset_n) begin
            if (bus.done) begin done_cnt++; chk("busy_in_done", bus.busy, 1); end
            if (bus.error) begin err_cnt++; chk("error_with_done", bus.done, 1); end
         end
      end
   end

   // Bridge model: wait states, FIFO of written words, irq level
   initial begin
      bus.av_wait_request = 1'b0;
      bus.av_read_data    = '0;
      bus.irq             = 1'b0;
      forever begin
         @(negedge clk_120MHz);
         if (!reset_n) begin in_acc = 1'b0; bus.av_wait_request = 1'b0; bus.irq = 1'b0; continue; end
         if (bus.av_chip_select || bus.av_write || bus.av_read)
            chk("bus_cs_one_strobe", {bus.av_chip_select, bus.av_write ^ bus.av_read}, 2'b11);
         if (bus.av_chip_select && (bus.av_write || bus.av_read)) begin
            if (!in_acc) begin
               in_acc = 1'b1; acc_len = 0;
               acc_wr = bus.av_write; acc_addr = bus.av_address; acc_wd = bus.av_write_data;
               chk("access_addr", bus.av_address, bus.av_write ? TX_ADDR : RX_ADDR);
               if (bus.av_read) chk("read_while_rx_valid", bus.rx_valid, 0);
               case (stall_mode)
                  0:       stall = $urandom_range(0, 3);
                  1:       stall = 5;
                  default: stall = 1000000;
               endcase
            end else begin
               chk("stall_hold_addr", bus.av_address, acc_addr);
               chk("stall_hold_dir", bus.av_write, acc_wr);
               if (acc_wr) chk("stall_hold_wdata", bus.av_write_data, acc_wd);
            end
            acc_len++;
            if (stall > 0) begin
               bus.av_wait_request = 1'b1;
               stall--;
            end else begin
               bus.av_wait_request = 1'b0;
               if (bus.av_write) begin
                  slv_fifo.push_back(bus.av_write_data);
                  wr_total++;
                  chk("outstanding_le_max", slv_fifo.size() <= MAX_OUT, 1);
               end else if (slv_fifo.size() == 0) begin
                  fail("read_empty", "read issued with no word in bridge");
               end else begin
                  bus.av_read_data = xf(slv_fifo.pop_front());
                  rd_total++;
               end
            end
         end else begin
            if (in_acc) last_len = acc_len;
            in_acc = 1'b0;
            bus.av_wait_request = 1'b0;
         end
         bus.irq = (irq_en != 0) && (slv_fifo.size() > 0);
      end
   end

   task automatic begin_burst(input int n);
      d0 = done_cnt; e0 = err_cnt; w0 = wr_total; r0 = rd_total; x0 = rx_cnt;
      @(posedge clk_120MHz); #1;
      bus.start = 1'b1;
      bus.len   = 8'(n);
      @(posedge clk_120MHz); #1;
      bus.start = 1'b0;
      bus.len   = 8'($urandom);
      @(negedge clk_120MHz); #3;
      chk("busy_after_start", bus.busy, 1);
      chk("done_after_start", bus.done, (n == 0));
   endtask

   task automatic finish_burst(input int n, input int exp_err);
      int k = 0;
      while (done_cnt == d0 && k < 3000) begin @(negedge clk_120MHz); #3; k++; end
      if (done_cnt == d0) fail("done_wait", $sformatf("no done within %0d cycles, required 1 pulse", k));
      @(negedge clk_120MHz); #3;
      chk("busy_after_done", bus.busy, 0);
      chk("done_pulses", done_cnt - d0, 1);
      chk("error_pulses", err_cnt - e0, exp_err);
      if (exp_err == 0) begin
         k = 0;
         while (exp_q.size() != 0 && k < 500) begin @(negedge clk_120MHz); #3; k++; end
         chk("rx_drained", exp_q.size(), 0);
         chk("rx_words", rx_cnt - x0, n);
         chk("writes", wr_total - w0, n);
         chk("reads", rd_total - r0, n);
      end
   endtask

   task automatic cleanup();
      tx_src.delete();
      repeat (2) @(negedge clk_120MHz);
      #3;
      exp_q.delete();
      slv_fifo.delete();
   endtask

   initial begin
      int k, n;
      bus.start = 1'b0;
      bus.len   = '0;

      // Reset values
      repeat (3) @(negedge clk_120MHz);
      #3;
      chk("rst_busy", bus.busy, 0);          chk("rst_done", bus.done, 0);
      chk("rst_error", bus.error, 0);        chk("rst_tx_ready", bus.tx_ready, 0);
      chk("rst_rx_valid", bus.rx_valid, 0);  chk("rst_cs", bus.av_chip_select, 0);
      chk("rst_write", bus.av_write, 0);     chk("rst_read", bus.av_read, 0);
      chk("rst_addr", bus.av_address, 0);    chk("rst_wdata", bus.av_write_data, 0);
      chk("rst_rx_data", bus.rx_data, 0);
      @(posedge clk_120MHz); #1;
      reset_n = 1'b1;

      // Three fixed words, no wait states, always ready
      stall_mode = 0; rx_mode = 0; irq_en = 1;
      tx_src = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
      begin_burst(3);
      finish_burst(3, 0);

      // Outstanding throttle: irq held off until four writes land
      irq_en = 0;
      for (int i = 0; i < 8; i++) tx_src.push_back($urandom);
      begin_burst(8);
      k = 0;
      while (wr_total - w0 < 4 && k < 200) begin @(negedge clk_120MHz); #3; k++; end
      n = 0;
      repeat (15) begin @(negedge clk_120MHz); #3; n += int'(bus.tx_ready); end
      chk("tx_ready_throttled", n, 0);
      chk("writes_before_irq", wr_total - w0, 4);
      chk("bridge_depth", slv_fifo.size(), 4);
      irq_en = 1;
      finish_burst(8, 0);

      // Five wait states on every access
      stall_mode = 1;
      tx_src = '{32'hA0A0_0001, 32'h0B0B_0002};
      begin_burst(2);
      finish_burst(2, 0);

      // Stuck wait request: timeout
      stall_mode = 2;
      tx_src = '{32'hDEAD_BEEF, 32'hCAFE_F00D};
      begin_burst(2);
      finish_burst(2, 1);
      chk("timeout_stall_cycles", last_len, TIMEOUT);
      stall_mode = 0;
      cleanup();

      // Sink stalled 20 cycles: no second read, rx_data held
      rx_mode = 2;
      for (int i = 0; i < 3; i++) tx_src.push_back($urandom);
      begin_burst(3);
      k = 0;
      while (!bus.rx_valid && k < 100) begin @(negedge clk_120MHz); #3; k++; end
      chk("rx_valid_seen", bus.rx_valid, 1);
      repeat (20) @(negedge clk_120MHz);
      #3;
      chk("single_read_while_held", rd_total - r0, 1);
      rx_mode = 0;
      finish_burst(3, 0);

      // Asynchronous reset during a write stall
      stall_mode = 2;
      tx_src = '{32'h1234_5678, 32'h9ABC_DEF0};
      begin_burst(2);
      k = 0;
      while (!bus.av_write && k < 50) begin @(negedge clk_120MHz); #3; k++; end
      repeat (3) @(negedge clk_120MHz);
      #4;
      reset_n = 1'b0;
      #1;
      chk("arst_write", bus.av_write, 0);
      chk("arst_cs", bus.av_chip_select, 0);
      chk("arst_busy", bus.busy, 0);
      stall_mode = 0;
      cleanup();
      reset_n = 1'b1;
      tx_src = '{32'h0F0F_1E1E};
      begin_burst(1);
      finish_burst(1, 0);

      // Randomized bursts; a stray start mid-burst must be ignored
      rx_mode = 1;
      for (int b = 0; b < 6; b++) begin
         n = $urandom_range(1, 12);
         for (int i = 0; i < n; i++) tx_src.push_back($urandom);
         begin_burst(n);
         if (b == 0) begin
            repeat (4) @(posedge clk_120MHz);
            #1;
            bus.start = 1'b1; bus.len = 8'd0;
            @(posedge clk_120MHz); #1;
            bus.start = 1'b0;
         end
         finish_burst(n, 0);
      end
      rx_mode = 0;

      // Empty burst
      begin_burst(0);
      finish_burst(0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Global watchdog
   initial begin
      #500000;
      fail("watchdog", "simulation time limit reached, required normal completion");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
